// File: rtl/crc_16_chk.sv
// crc_16_chk: receive-side USB CRC16 checker.
// Consumes the destuffed payload plus its inverted CRC16 field one bit per enabled cycle,
// in wire order, and issues a registered one-cycle pass/fail verdict after each eop.
// Polynomial x^16+x^15+x^2+1 (16'h8005), preset INIT; a good packet leaves RESIDUAL.
// Optional build macro CRC16_CHK_BYTE_ALIGN_EN: also fail packets whose bit count is not a
// whole number of bytes, flagged on the extra err_align_o output.
`timescale 1ns/1ps

module crc_16_chk #(
    parameter logic [15:0] INIT     = 16'hFFFF,
    parameter logic [15:0] RESIDUAL = 16'h800D,
    parameter int unsigned BCW      = 11
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clear_i,
    input  logic           shift_enable_i,
    input  logic           serial_in_i,
    input  logic           eop_i,
    output logic           crc_ok_o,
    output logic           crc_err_o,
    output logic           err_short_o,
`ifdef CRC16_CHK_BYTE_ALIGN_EN
    output logic           err_align_o,
`endif
    output logic           busy_o,
    output logic [BCW-1:0] bit_count_o,
    output logic [15:0]    crc_reg_o
);

    localparam logic [15:0]    Poly    = 16'h8005;
    localparam logic [BCW-1:0] CntMax  = '1;
    localparam logic [BCW-1:0] CntOne  = BCW'(1);
    localparam int unsigned    MinBits = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StVerdict
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    crc_q, crc_d, crc_post;
    logic [BCW-1:0] cnt_q, cnt_d, cnt_post;
    logic           ok_q, ok_d;
    logic           err_q, err_d;
    logic           short_q, short_d;
    logic           busy_q, busy_d;
    logic           fb;
    logic           is_short;
    logic           is_match;
`ifdef CRC16_CHK_BYTE_ALIGN_EN
    logic           align_q, align_d;
    logic           is_misaligned;
`endif

    // Remainder and bit count as they stand after this cycle's bit, if any.
    always_comb begin
        fb       = serial_in_i ^ crc_q[15];
        crc_post = crc_q;
        cnt_post = cnt_q;
        if (shift_enable_i) begin
            crc_post = {crc_q[14:0], 1'b0} ^ (fb ? Poly : 16'h0000);
            if (cnt_q != CntMax) begin
                cnt_post = cnt_q + CntOne;
            end
        end
        // The verdict includes a bit shifted in the eop cycle itself.
        is_short = 32'(cnt_post) < MinBits;
        is_match = (crc_post == RESIDUAL);
`ifdef CRC16_CHK_BYTE_ALIGN_EN
        is_misaligned = (cnt_post[2:0] != 3'b000);
`endif
    end

    // Next state, next remainder/counter and the verdict pulses.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_post;
        cnt_d   = cnt_post;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        short_d = 1'b0;
`ifdef CRC16_CHK_BYTE_ALIGN_EN
        align_d = 1'b0;
`endif
        if (clear_i) begin
            // Abort: discards any bit and any verdict this cycle.
            state_d = StIdle;
            crc_d   = INIT;
            cnt_d   = '0;
        end else if (eop_i) begin
            state_d = StVerdict;
            crc_d   = INIT;
            cnt_d   = '0;
            if (is_short) begin
                err_d   = 1'b1;
                short_d = 1'b1;
`ifdef CRC16_CHK_BYTE_ALIGN_EN
            end else if (is_misaligned) begin
                err_d   = 1'b1;
                align_d = 1'b1;
`endif
            end else if (is_match) begin
                ok_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (shift_enable_i) begin
            // From IDLE or VERDICT this bit opens a new packet.
            state_d = StRun;
        end else if (state_q == StVerdict) begin
            state_d = StIdle;
        end
        busy_d = (state_d == StRun);
    end

    // FSM, datapath and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            crc_q   <= INIT;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            short_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CRC16_CHK_BYTE_ALIGN_EN
            align_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            short_q <= short_d;
            busy_q  <= busy_d;
`ifdef CRC16_CHK_BYTE_ALIGN_EN
            align_q <= align_d;
`endif
        end
    end

    assign crc_ok_o    = ok_q;
    assign crc_err_o   = err_q;
    assign err_short_o = short_q;
    assign busy_o      = busy_q;
    assign bit_count_o = cnt_q;
    assign crc_reg_o   = crc_q;
`ifdef CRC16_CHK_BYTE_ALIGN_EN
    assign err_align_o = align_q;
`endif

endmodule

// File: tb/tb_crc_16_chk.sv
// Directed testbench for crc_16_chk. Build with CRC16_CHK_BYTE_ALIGN_EN defined to
// exercise the byte-alignment check as well.
`timescale 1ns/1ps

module tb_crc_16_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        se = 1'b0;
    logic        sin = 1'b0;
    logic        eop = 1'b0;
    logic        ok, err, short_f, busy;
    logic [10:0] bcnt;
    logic [15:0] crc;
`ifdef CRC16_CHK_BYTE_ALIGN_EN
    logic        align;
`endif

    int checks = 0;
    int failures = 0;

    crc_16_chk dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .shift_enable_i (se),
        .serial_in_i    (sin),
        .eop_i          (eop),
        .crc_ok_o       (ok),
        .crc_err_o      (err),
        .err_short_o    (short_f),
`ifdef CRC16_CHK_BYTE_ALIGN_EN
        .err_align_o    (align),
`endif
        .busy_o         (busy),
        .bit_count_o    (bcnt),
        .crc_reg_o      (crc)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; returns 1 ns after the edge.
    task automatic drive(input logic s, input logic b, input logic e, input logic c);
        se = s; sin = b; eop = e; clear = c;
        @(posedge clk);
        #1;
        se = 1'b0; sin = 1'b0; eop = 1'b0; clear = 1'b0;
    endtask

    task automatic send_const(input logic b, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic send_stream(input logic [63:0] s, input int first, input int last);
        for (int i = first; i < last; i++) drive(1'b1, s[i], 1'b0, 1'b0);
    endtask

    // Transmit-side generator: payload LSB first, then the inverted remainder MSB first.
    task automatic build_packet(input logic [15:0] payload, input int plen,
                                output logic [63:0] s, output int n);
        logic [15:0] c;
        logic        f;
        c = 16'hFFFF;
        s = '0;
        for (int i = 0; i < plen; i++) begin
            s[i] = payload[i];
            f = payload[i] ^ c[15];
            c = {c[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
        end
        for (int j = 0; j < 16; j++) s[plen+j] = ~c[15-j];
        n = plen + 16;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ok, err, short_f} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b expected 000", {ok, err, short_f});
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (crc !== 16'hFFFF) begin
            failures++; $display("FAIL reset_crc: got %h expected ffff", crc);
        end
        checks++;
        if (bcnt !== 11'd0) begin
            failures++; $display("FAIL reset_count: got %0d expected 0", bcnt);
        end
`ifdef CRC16_CHK_BYTE_ALIGN_EN
        checks++;
        if (align !== 1'b0) begin
            failures++; $display("FAIL reset_align: got %b expected 0", align);
        end
`endif
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_empty_packet();
        send_const(1'b0, 16);
        checks++;
        if ({busy, bcnt, crc} !== {1'b1, 11'd16, 16'h800D}) begin
            failures++;
            $display("FAIL empty_pre_eop: got busy=%b cnt=%0d crc=%h expected 1 16 800d",
                     busy, bcnt, crc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b100) begin
            failures++; $display("FAIL empty_verdict: got %b expected 100", {ok, err, short_f});
        end
        checks++;
        if ({busy, bcnt, crc} !== {1'b0, 11'd0, 16'hFFFF}) begin
            failures++;
            $display("FAIL empty_reinit: got busy=%b cnt=%0d crc=%h expected 0 0 ffff",
                     busy, bcnt, crc);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b000) begin
            failures++; $display("FAIL empty_pulse_len: got %b expected 000", {ok, err, short_f});
        end
    endtask

    task automatic test_all_ones();
        send_const(1'b1, 16);
        checks++;
        if (crc !== 16'h0000) begin
            failures++; $display("FAIL ones_crc: got %h expected 0000", crc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b010) begin
            failures++; $display("FAIL ones_verdict: got %b expected 010", {ok, err, short_f});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_short();
        send_const(1'b0, 8);
        checks++;
        if (bcnt !== 11'd8) begin
            failures++; $display("FAIL short_count: got %0d expected 8", bcnt);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b011) begin
            failures++; $display("FAIL short_verdict: got %b expected 011", {ok, err, short_f});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f, busy} !== 4'b0110) begin
            failures++;
            $display("FAIL idle_eop: got %b expected 0110", {ok, err, short_f, busy});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b000) begin
            failures++; $display("FAIL idle_eop_len: got %b expected 000", {ok, err, short_f});
        end
    endtask

    task automatic test_a5_packet();
        logic [63:0] s, s2;
        int          n;
        int          pos [4] = '{0, 5, 13, 23};
        build_packet(16'h00A5, 8, s, n);
        send_stream(s, 0, n);
        checks++;
        if ({bcnt, crc} !== {11'd24, 16'h800D}) begin
            failures++;
            $display("FAIL a5_pre_eop: got cnt=%0d crc=%h expected 24 800d", bcnt, crc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b100) begin
            failures++; $display("FAIL a5_good: got %b expected 100", {ok, err, short_f});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        foreach (pos[k]) begin
            s2 = s ^ (64'd1 << pos[k]);
            send_stream(s2, 0, n);
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({ok, err, short_f} !== 3'b010) begin
                failures++;
                $display("FAIL a5_flip%0d: got %b expected 010", pos[k], {ok, err, short_f});
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        // Final CRC bit shares the eop cycle.
        send_stream(s, 0, n - 1);
        drive(1'b1, s[n-1], 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b100) begin
            failures++; $display("FAIL a5_eop_bit_good: got %b expected 100", {ok, err, short_f});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        send_stream(s, 0, n - 1);
        drive(1'b1, ~s[n-1], 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b010) begin
            failures++; $display("FAIL a5_eop_bit_bad: got %b expected 010", {ok, err, short_f});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] s;
        int          n;
        build_packet(16'h00A5, 8, s, n);
        send_const(1'b0, 16);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b100) begin
            failures++; $display("FAIL b2b_first: got %b expected 100", {ok, err, short_f});
        end
        // This bit lands in the VERDICT cycle and opens packet two.
        drive(1'b1, s[0], 1'b0, 1'b0);
        checks++;
        if ({busy, bcnt} !== {1'b1, 11'd1}) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%b cnt=%0d expected 1 1", busy, bcnt);
        end
        send_stream(s, 1, n);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b100) begin
            failures++; $display("FAIL b2b_second: got %b expected 100", {ok, err, short_f});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        // clear together with eop suppresses the verdict.
        send_const(1'b0, 16);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({ok, err, short_f, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL clear_eop: got %b expected 0000", {ok, err, short_f, busy});
        end
        checks++;
        if ({bcnt, crc} !== {11'd0, 16'hFFFF}) begin
            failures++;
            $display("FAIL clear_eop_reinit: got cnt=%0d crc=%h expected 0 ffff", bcnt, crc);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b000) begin
            failures++; $display("FAIL clear_eop_after: got %b expected 000", {ok, err, short_f});
        end
        // clear ignores a concurrent shift.
        send_const(1'b1, 5);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({busy, bcnt, crc} !== {1'b0, 11'd0, 16'hFFFF}) begin
            failures++;
            $display("FAIL clear_shift: got busy=%b cnt=%0d crc=%h expected 0 0 ffff",
                     busy, bcnt, crc);
        end
    endtask

    task automatic test_hold_and_saturation();
        send_const(1'b1, 3);
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({busy, bcnt, crc} !== {1'b1, 11'd3, 16'hFFF8}) begin
            failures++;
            $display("FAIL hold: got busy=%b cnt=%0d crc=%h expected 1 3 fff8", busy, bcnt, crc);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        send_const(1'b0, 2050);
        checks++;
        if (bcnt !== 11'h7FF) begin
            failures++; $display("FAIL saturate: got %0d expected 2047", bcnt);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_packet();
        send_const(1'b1, 5);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, bcnt, crc} !== {1'b0, 11'd0, 16'hFFFF}) begin
            failures++;
            $display("FAIL rst_mid: got busy=%b cnt=%0d crc=%h expected 0 0 ffff",
                     busy, bcnt, crc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f} !== 3'b000) begin
            failures++; $display("FAIL rst_mid_verdict: got %b expected 000", {ok, err, short_f});
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef CRC16_CHK_BYTE_ALIGN_EN
    task automatic test_align();
        logic [63:0] s;
        int          n;
        build_packet(16'h01A5, 9, s, n);
        send_stream(s, 0, n);
        checks++;
        if ({bcnt, crc} !== {11'd25, 16'h800D}) begin
            failures++;
            $display("FAIL align_pre_eop: got cnt=%0d crc=%h expected 25 800d", bcnt, crc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f, align} !== 4'b0101) begin
            failures++;
            $display("FAIL align_25: got %b expected 0101", {ok, err, short_f, align});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        build_packet(16'h00A5, 8, s, n);
        send_stream(s, 0, n);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ok, err, short_f, align} !== 4'b1000) begin
            failures++;
            $display("FAIL align_24: got %b expected 1000", {ok, err, short_f, align});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_empty_packet();
        test_all_ones();
        test_short();
        test_a5_packet();
        test_back_to_back();
        test_hold_and_saturation();
        test_reset_mid_packet();
`ifdef CRC16_CHK_BYTE_ALIGN_EN
        test_align();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_16_chk.md
# crc_16_chk

Receive-side CRC16 checker for the USB bulk-transfer datapath. It consumes the destuffed serial bit stream of a data-packet payload plus its appended 16-bit CRC field, one bit per enabled cycle, in wire order. At end of packet it issues a single-cycle pass/fail verdict to the receive controller. It mirrors the transmit-side CRC16 generator: same polynomial, same initial value, same bit order.

## Interface
- `INIT`, 16'hFFFF: remainder preset at reset, on `clear`, and at each verdict.
- `RESIDUAL`, 16'h800D: remainder value that indicates a good packet. This is the constant residual when the CRC is transmitted inverted.
- `BCW`, 11: width of the saturating bit counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous abort or reinit; highest priority after `rst`.
- `shift_enable` input 1: `serial_in` is valid this cycle.
- `serial_in` input 1: received bit, in wire order.
- `eop` input 1: one-cycle end-of-packet strobe.
- `crc_ok` output 1: one-cycle pulse, packet passed.
- `crc_err` output 1: one-cycle pulse, packet failed.
- `err_short` output 1: qualifies `crc_err`; fewer than 16 bits were received.
- `busy` output 1: high in RUN state.
- `bit_count` output BCW: bits shifted in the current packet; saturates at all-ones.
- `crc_reg` output 16: live remainder, for debug.

## Operation
- Polynomial x^16+x^15+x^2+1, encoded as 16'h8005.
- Per shift: `fb = serial_in ^ crc_reg[15]`, then `crc_reg <= {crc_reg[14:0],1'b0} ^ (fb ? 16'h8005 : 16'h0)`.
- States:
  - IDLE → RUN on `shift_enable` (first bit is shifted that cycle).
  - RUN → VERDICT on `eop`.
  - VERDICT → IDLE, or → RUN if `shift_enable` is high.
  - Any state → IDLE on `clear`.
- Verdict is evaluated in the `eop` cycle on the post-shift remainder. If `shift_enable` is also high in that cycle, that bit is included as the final bit.
- Verdict rules:
  - Bit count (including any bit shifted in the `eop` cycle) < 16 → `crc_err`=1, `err_short`=1.
  - Else remainder == RESIDUAL → `crc_ok`.
  - Else `crc_err`.
- In the `eop` cycle, `crc_reg` is loaded with INIT and `bit_count` with 0. A bit arriving in VERDICT is therefore the first bit of the next packet.
- `eop` in IDLE (no bits received) → `crc_err`+`err_short` pulse. State goes to VERDICT.
- `clear`:
  - Loads INIT and zeroes `bit_count`.
  - Suppresses any verdict, including when `clear` and `eop` coincide.
  - Ignores `shift_enable` that cycle.
- `shift_enable` low: remainder and counter hold.
- `bit_count` saturates at 2^BCW−1; the remainder keeps updating.

## Timing
- Reset values: `crc_reg`=INIT, `bit_count`=0, `crc_ok`=`crc_err`=`err_short`=0, `busy`=0, state IDLE.
- `crc_ok`, `crc_err` and `err_short` are registered. They are high exactly the one cycle after the `eop` edge, and are never high together with each other except `err_short` with `crc_err`.
- `crc_reg` and `bit_count` reflect a shifted bit one cycle after the `shift_enable` edge.
- `busy` is high from the cycle after the first bit until the cycle after `eop`.
- `rst` mid-packet: all outputs go to reset values immediately; no verdict is produced.

## Configuration
- `CRC16_CHK_BYTE_ALIGN_EN` defined:
  - A packet with bit count ≥ 16 and `bit_count[2:0]` ≠ 0 at `eop` gives `crc_err`, even if the remainder matches.
  - Adds output `err_align` (1 bit, registered, reset 0). It pulses together with `crc_err` for this cause only.
- Undefined: alignment is not checked and the `err_align` port is absent.

## Test plan
- After `rst`: 16 zero bits, then `eop` → `crc_ok`=1 for one cycle, `crc_reg` back to 16'hFFFF, `bit_count`=0. This is the empty DATA packet, whose CRC field is 0x0000.
- 16 one-bits, then `eop` → `crc_reg` is 16'h0000 before `eop`; `crc_err`=1, `err_short`=0.
- 8 bits then `eop` → `crc_err`=1, `err_short`=1. `eop` in IDLE → same pulse pair.
- Payload 8'hA5 plus its correct inverted CRC from the bench model → `crc_ok`. Same stream with any single bit flipped → `crc_err`. Last CRC bit presented together with `eop` → same verdicts.
- Back-to-back packets: the bit in the VERDICT cycle starts the second packet. Both verdicts are correct; `clear` asserted with `eop` gives no pulse.
- With `CRC16_CHK_BYTE_ALIGN_EN` defined: a 25-bit stream whose remainder equals 16'h800D → `crc_err`=1, `err_align`=1. A 24-bit good packet → `crc_ok`.
